// File: rtl/video_timing_detector.sv
// Measures an incoming hsync/vsync/data-enable stream and reports line and frame geometry once
// LOCK_FRAMES consecutive identical, self-consistent frames have been seen.
module video_timing_detector #(
  parameter int unsigned WIDTH       = 11,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic             hSyncIn,
  input  logic             vSyncIn,
  input  logic             dataEnable,
  output logic [WIDTH-1:0] hTotal,
  output logic [WIDTH-1:0] hActive,
  output logic [WIDTH-1:0] vTotal,
  output logic [WIDTH-1:0] vActive,
  output logic             locked,
  output logic             timingError
);

  localparam logic [WIDTH-1:0] CntZero    = '0;
  localparam logic [WIDTH-1:0] CntOne     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] CntMax     = '1;
  localparam logic [WIDTH-1:0] CntPreMax  = {{(WIDTH-1){1'b1}}, 1'b0};
  localparam logic [3:0]       LockFrames = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {StSearch, StMeasure, StLocked} stateT;

  // Input registers and edge detection
  logic hSyncQ, hPrevQ, vSyncQ, vPrevQ, deQ;
  logic hRise, vRise;

  // Per-line counters
  logic [WIDTH-1:0] hCntQ, hCntD, deCntQ, deCntD, linePeriod;
  logic             timeout, deOvf;

  // Per-frame accumulation
  logic [WIDTH-1:0] firstPeriodQ, firstDeQ, vCntQ, vActCntQ;
  logic             firstPeriodVldQ, firstDeVldQ, inconsQ;
  logic [WIDTH-1:0] fPeriod, fDe, fV, fVAct;
  logic             fPeriodVld, fDeVld, fIncons, vOvf;

  // Lock state machine
  stateT            stateQ, stateD;
  logic [3:0]       matchQ, matchD;
  logic [WIDTH-1:0] candHQ, candHAQ, candVQ, candVAQ;
  logic [WIDTH-1:0] candHD, candHAD, candVD, candVAD;
  logic [WIDTH-1:0] hTotalQ, hActiveQ, vTotalQ, vActiveQ;
  logic [WIDTH-1:0] hTotalD, hActiveD, vTotalD, vActiveD;
  logic             timingErrorQ, timingErrorD;
  logic             consistent, candEqStored, candEqOut, anyError;

  // Sync registers reset high so a sync held high through reset is not seen as an edge
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      hSyncQ <= 1'b1;
      hPrevQ <= 1'b1;
      vSyncQ <= 1'b1;
      vPrevQ <= 1'b1;
      deQ    <= 1'b0;
    end else begin
      hSyncQ <= hSyncIn;
      hPrevQ <= hSyncQ;
      vSyncQ <= vSyncIn;
      vPrevQ <= vSyncQ;
      deQ    <= dataEnable;
    end
  end

  assign hRise      = hSyncQ & ~hPrevQ;
  assign vRise      = vSyncQ & ~vPrevQ;
  assign linePeriod = hCntQ + CntOne;

  always_comb begin
    hCntD   = hCntQ;
    deCntD  = deCntQ;
    timeout = 1'b0;
    deOvf   = 1'b0;
    if (hRise) begin
      hCntD  = CntZero;
      deCntD = {{(WIDTH-1){1'b0}}, deQ};
    end else begin
      // hCnt sitting at its maximum means 2^WIDTH clocks without a line start
      if (hCntQ == CntMax) begin
        timeout = 1'b1;
      end else begin
        hCntD = hCntQ + CntOne;
      end
      if (deQ && (deCntQ != CntMax)) begin
        deCntD = deCntQ + CntOne;
        deOvf  = (deCntQ == CntPreMax);
      end
    end
  end

  // Frame view including the line that closes this cycle, so a coincident vRise sees it
  always_comb begin
    fPeriod    = firstPeriodQ;
    fPeriodVld = firstPeriodVldQ;
    fDe        = firstDeQ;
    fDeVld     = firstDeVldQ;
    fV         = vCntQ;
    fVAct      = vActCntQ;
    fIncons    = inconsQ;
    vOvf       = 1'b0;
    if (hRise) begin
      if (!firstPeriodVldQ) begin
        fPeriod    = linePeriod;
        fPeriodVld = 1'b1;
      end else if (linePeriod != firstPeriodQ) begin
        fIncons = 1'b1;
      end
      if (deCntQ != CntZero) begin
        if (!firstDeVldQ) begin
          fDe    = deCntQ;
          fDeVld = 1'b1;
        end else if (deCntQ != firstDeQ) begin
          fIncons = 1'b1;
        end
        if (vActCntQ != CntMax) begin
          fVAct = vActCntQ + CntOne;
          vOvf  = (vActCntQ == CntPreMax);
        end
      end
      if (vCntQ != CntMax) begin
        fV = vCntQ + CntOne;
        if (vCntQ == CntPreMax) vOvf = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      hCntQ           <= CntZero;
      deCntQ          <= CntZero;
      firstPeriodQ    <= CntZero;
      firstPeriodVldQ <= 1'b0;
      firstDeQ        <= CntZero;
      firstDeVldQ     <= 1'b0;
      vCntQ           <= CntZero;
      vActCntQ        <= CntZero;
      inconsQ         <= 1'b0;
    end else begin
      hCntQ  <= hCntD;
      deCntQ <= deCntD;
      if (vRise) begin
        firstPeriodQ    <= CntZero;
        firstPeriodVldQ <= 1'b0;
        firstDeQ        <= CntZero;
        firstDeVldQ     <= 1'b0;
        vCntQ           <= CntZero;
        vActCntQ        <= CntZero;
        inconsQ         <= 1'b0;
      end else begin
        firstPeriodQ    <= fPeriod;
        firstPeriodVldQ <= fPeriodVld;
        firstDeQ        <= fDe;
        firstDeVldQ     <= fDeVld;
        vCntQ           <= fV;
        vActCntQ        <= fVAct;
        inconsQ         <= fIncons;
      end
    end
  end

  assign consistent   = ~fIncons;
  assign candEqStored = ({fPeriod, fDe, fV, fVAct} == {candHQ, candHAQ, candVQ, candVAQ});
  assign candEqOut    = ({fPeriod, fDe, fV, fVAct} == {hTotalQ, hActiveQ, vTotalQ, vActiveQ});
  assign anyError     = timeout | deOvf | vOvf;

  always_comb begin
    stateD       = stateQ;
    matchD       = matchQ;
    candHD       = candHQ;
    candHAD      = candHAQ;
    candVD       = candVQ;
    candVAD      = candVAQ;
    hTotalD      = hTotalQ;
    hActiveD     = hActiveQ;
    vTotalD      = vTotalQ;
    vActiveD     = vActiveQ;
    timingErrorD = timingErrorQ | anyError;
    unique case (stateQ)
      StSearch: begin
        if (vRise) begin
          stateD = StMeasure;
          matchD = 4'd0;
        end
      end
      StMeasure: begin
        if (vRise) begin
          if (!consistent) begin
            matchD = 4'd0;
          end else begin
            if (candEqStored) begin
              matchD = (matchQ == 4'hF) ? matchQ : matchQ + 4'd1;
            end else begin
              matchD = 4'd1;
            end
            candHD  = fPeriod;
            candHAD = fDe;
            candVD  = fV;
            candVAD = fVAct;
            if (matchD >= LockFrames) begin
              stateD   = StLocked;
              hTotalD  = fPeriod;
              hActiveD = fDe;
              vTotalD  = fV;
              vActiveD = fVAct;
            end
          end
        end
      end
      StLocked: begin
        if (vRise && (!consistent || !candEqOut)) begin
          stateD   = StMeasure;
          hTotalD  = CntZero;
          hActiveD = CntZero;
          vTotalD  = CntZero;
          vActiveD = CntZero;
          matchD   = consistent ? 4'd1 : 4'd0;
          if (consistent) begin
            candHD  = fPeriod;
            candHAD = fDe;
            candVD  = fV;
            candVAD = fVAct;
          end
        end
      end
      default: stateD = StSearch;
    endcase
    if (anyError) begin
      stateD   = StSearch;
      matchD   = 4'd0;
      hTotalD  = CntZero;
      hActiveD = CntZero;
      vTotalD  = CntZero;
      vActiveD = CntZero;
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      stateQ       <= StSearch;
      matchQ       <= 4'd0;
      candHQ       <= CntZero;
      candHAQ      <= CntZero;
      candVQ       <= CntZero;
      candVAQ      <= CntZero;
      hTotalQ      <= CntZero;
      hActiveQ     <= CntZero;
      vTotalQ      <= CntZero;
      vActiveQ     <= CntZero;
      timingErrorQ <= 1'b0;
    end else begin
      stateQ       <= stateD;
      matchQ       <= matchD;
      candHQ       <= candHD;
      candHAQ      <= candHAD;
      candVQ       <= candVD;
      candVAQ      <= candVAD;
      hTotalQ      <= hTotalD;
      hActiveQ     <= hActiveD;
      vTotalQ      <= vTotalD;
      vActiveQ     <= vActiveD;
      timingErrorQ <= timingErrorD;
    end
  end

  assign hTotal      = hTotalQ;
  assign hActive     = hActiveQ;
  assign vTotal      = vTotalQ;
  assign vActive     = vActiveQ;
  assign locked      = (stateQ == StLocked);
  assign timingError = timingErrorQ;

endmodule
